// File: rtl/mem_bridge.sv
// mem_bridge: bridges single block-sized cache requests onto a 64-bit beat
// memory port. Writes (evicts) are split into NB strobed write beats; reads
// issue NB address beats and collect NB in-order returns into a block buffer.
// One response cycle is produced per request.
module mem_bridge #(
    parameter int blk = 64,
    parameter int bw  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           s_rqst,
    input  logic [7:0]           s_trsc,
    input  logic [blk-1:0]       s_strb,
    input  logic [63:0]          s_addr,
    input  logic [blk*8-1:0]     s_wdat,
    output logic [7:0]           s_resp,
    output logic [7:0]           s_miss,
    output logic [63:0]          s_ofst,
    output logic [blk*8-1:0]     s_rdat,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [63:0]          mem_addr,
    output logic [7:0]           mem_wstrb,
    output logic [63:0]          mem_wdata,
    input  logic                 mem_ready,
    input  logic                 mem_rvalid,
    input  logic [63:0]          mem_rdata
);

    localparam int NB = blk / bw;
    localparam int OW = $clog2(blk);
    localparam int CW = $clog2(NB) + 1;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);
    localparam logic [CW-1:0] FULL = CW'(NB);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RDA,
        RDD,
        RESP
    } state_t;

    state_t state, nxt;

    logic [CW-1:0]      k;
    logic [CW-1:0]      r;
    logic [7:0]         rqst_q;
    logic [63:0]        base_q;
    logic [blk-1:0]     strb_q;
    logic [blk*8-1:0]   wdat_q;
    logic [blk*8-1:0]   rbuf;

    logic               capture;
    logic               hs;
    logic               rd_take;
    logic [7:0]         beat_strb;
    logic [63:0]        beat_data;

    assign capture = (state == IDLE) && (s_rqst != '0);
    assign hs      = mem_req && mem_ready;
    // Returns only count while a read is in flight, and never past a full block.
    assign rd_take = mem_rvalid && ((state == RDA) || (state == RDD)) && (r < FULL);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next-state: reads may finish collecting returns while still issuing,
    // so the last issue beat can jump straight to RESP.
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (s_rqst != '0) begin
                    nxt = (s_trsc == 8'd0) ? WR : RDA;
                end
            end
            WR: begin
                if (hs && (k == LAST)) begin
                    nxt = RESP;
                end
            end
            RDA: begin
                if (hs && (k == LAST)) begin
                    if ((r == FULL) || (rd_take && (r == LAST))) begin
                        nxt = RESP;
                    end else begin
                        nxt = RDD;
                    end
                end
            end
            RDD: begin
                if (rd_take && (r == LAST)) begin
                    nxt = RESP;
                end
            end
            RESP: begin
                nxt = IDLE;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    // Issue and return counters; both restart when a request is captured.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k <= '0;
            r <= '0;
        end else if (capture) begin
            k <= '0;
            r <= '0;
        end else begin
            if (hs) begin
                k <= k + 1'b1;
            end
            if (rd_take) begin
                r <= r + 1'b1;
            end
        end
    end

    // Latched request ID, the only request field that needs a reset value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rqst_q <= '0;
        end else if (capture) begin
            rqst_q <= s_rqst;
        end
    end

    // Request payload capture with the block offset bits cleared.
    always_ff @(posedge clk) begin
        if (capture) begin
            base_q <= {s_addr[63:OW], {OW{1'b0}}};
            strb_q <= s_strb;
            wdat_q <= s_wdat;
        end
    end

    // Read buffer fill: return r lands in beat slot r.
    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < NB; b++) begin
            if (rd_take && (r == CW'(b))) begin
                rbuf[b*64 +: 64] <= mem_rdata;
            end
        end
    end

    // Current beat strobe/data selected by the issue counter.
    always_comb begin
        beat_strb = '0;
        beat_data = '0;
        for (int unsigned b = 0; b < NB; b++) begin
            if (k == CW'(b)) begin
                beat_strb = strb_q[b*8 +: 8];
                beat_data = wdat_q[b*64 +: 64];
            end
        end
    end

    // Memory-side and cache-side output decode.
    always_comb begin
        mem_req   = (state == WR) || (state == RDA);
        mem_we    = (state == WR);
        mem_addr  = base_q + (64'(k) << 3);
        mem_wstrb = (state == WR) ? beat_strb : 8'h00;
        mem_wdata = beat_data;
        s_resp    = (state == RESP) ? rqst_q : 8'h00;
        s_miss    = '0;
        s_ofst    = base_q;
        s_rdat    = rbuf;
    end

endmodule

// File: tb/tb_mem_bridge.sv
// Directed self-checking bench for mem_bridge with a zero/variable-wait memory
// that returns read beats one cycle after each accepted address.
module tb_mem_bridge;

    logic         clk;
    logic         rst;
    logic [7:0]   s_rqst;
    logic [7:0]   s_trsc;
    logic [63:0]  s_strb;
    logic [63:0]  s_addr;
    logic [511:0] s_wdat;
    logic [7:0]   s_resp;
    logic [7:0]   s_miss;
    logic [63:0]  s_ofst;
    logic [511:0] s_rdat;
    logic         mem_req;
    logic         mem_we;
    logic [63:0]  mem_addr;
    logic [7:0]   mem_wstrb;
    logic [63:0]  mem_wdata;
    logic         mem_ready;
    logic         mem_rvalid;
    logic [63:0]  mem_rdata;

    int total = 0;
    int bad = 0;

    logic         nxt_v = 1'b0;
    logic [63:0]  nxt_d = '0;
    logic         inj_rv = 1'b0;

    logic [63:0]  log_addr[$];
    logic         log_we[$];
    logic [7:0]   log_strb[$];
    logic [63:0]  log_data[$];
    logic [7:0]   rq_id[$];
    logic [63:0]  rq_ofst[$];
    logic [511:0] rq_dat[$];

    logic         prev_stall = 1'b0;
    logic [63:0]  sv_addr, sv_data;
    logic [7:0]   sv_strb;
    int           stall_bad = 0;
    int           stall_seen = 0;

    logic [511:0] exp_rd;
    logic [511:0] wd;
    logic [63:0]  e64;

    mem_bridge #(.blk(64), .bw(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_rqst     (s_rqst),
        .s_trsc     (s_trsc),
        .s_strb     (s_strb),
        .s_addr     (s_addr),
        .s_wdat     (s_wdat),
        .s_resp     (s_resp),
        .s_miss     (s_miss),
        .s_ofst     (s_ofst),
        .s_rdat     (s_rdat),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mid-cycle observer: logs handshakes, responses, and stall stability.
    always @(negedge clk) begin
        if (mem_req && mem_ready) begin
            log_addr.push_back(mem_addr);
            log_we.push_back(mem_we);
            log_strb.push_back(mem_wstrb);
            log_data.push_back(mem_wdata);
        end
        nxt_v = mem_req && mem_ready && !mem_we;
        nxt_d = 64'h1111_1111_1111_1111 * 64'(mem_addr[5:3]);
        if (s_resp != 8'h00) begin
            rq_id.push_back(s_resp);
            rq_ofst.push_back(s_ofst);
            rq_dat.push_back(s_rdat);
        end
        if (prev_stall) begin
            stall_seen++;
            if (!mem_req || mem_addr !== sv_addr || mem_wdata !== sv_data || mem_wstrb !== sv_strb)
                stall_bad++;
        end
        prev_stall = mem_req && !mem_ready;
        sv_addr = mem_addr;
        sv_data = mem_wdata;
        sv_strb = mem_wstrb;
    end

    // Read return path: one cycle after the accepting edge.
    always @(posedge clk) begin
        #2;
        mem_rvalid = nxt_v | inj_rv;
        mem_rdata  = nxt_d;
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        log_addr.delete();
        log_we.delete();
        log_strb.delete();
        log_data.delete();
        rq_id.delete();
        rq_ofst.delete();
        rq_dat.delete();
    endtask

    task automatic issue(input logic [7:0] rq, input logic [7:0] tr, input logic [63:0] a,
                         input logic [63:0] st, input logic [511:0] d);
        s_rqst = rq;
        s_trsc = tr;
        s_addr = a;
        s_strb = st;
        s_wdat = d;
        step();
        s_rqst = 8'h00;
    endtask

    task automatic wait_resp(input int want);
        int c = 0;
        while (rq_id.size() < want && c < 300) begin
            step();
            c++;
        end
        check("resp_count", rq_id.size(), want);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst = 1'b0;
        s_rqst = '0; s_trsc = '0; s_strb = '0; s_addr = '0; s_wdat = '0;
        mem_ready = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        for (int k = 0; k < 8; k++) exp_rd[k*64 +: 64] = 64'h1111_1111_1111_1111 * 64'(k);
        for (int i = 0; i < 64; i++) wd[i*8 +: 8] = 8'(i);

        // Reset state
        step();
        step();
        check("rst_resp", s_resp, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_wstrb", mem_wstrb, 0);
        check("miss_zero", s_miss, 0);
        rst = 1'b1;
        step();

        // Read 0x05 at 0x1047
        clear_logs();
        issue(8'h05, 8'h01, 64'h1047, '0, '0);
        wait_resp(1);
        check("rd_id", rq_id[0], 8'h05);
        check("rd_ofst", rq_ofst[0], 64'h1040);
        check("rd_data", rq_dat[0], exp_rd);
        check("rd_beats", log_addr.size(), 8);
        for (int k = 0; k < 8; k++) check("rd_addr", log_addr[k], 64'h1040 + 64'(8 * k));
        check("rd_we0", log_we[0], 1'b0);
        check("resp_one_cycle", s_resp, 0);
        step();
        check("rd_no_reissue", log_addr.size(), 8);

        // Evict 0x80, full strobe
        clear_logs();
        issue(8'h80, 8'h00, 64'h2000, '1, wd);
        wait_resp(1);
        check("wr_id", rq_id[0], 8'h80);
        check("wr_ofst", rq_ofst[0], 64'h2000);
        check("wr_beats", log_addr.size(), 8);
        check("wr_data0", log_data[0], 64'h0706050403020100);
        check("wr_strb0", log_strb[0], 8'hFF);
        check("wr_we0", log_we[0], 1'b1);
        check("wr_addr7", log_addr[7], 64'h2038);
        check("wr_data7", log_data[7], 64'h3F3E3D3C3B3A3938);

        // Write under backpressure: ready pattern 1,0,0 repeating
        clear_logs();
        stall_bad = 0;
        stall_seen = 0;
        issue(8'h11, 8'h00, 64'h4010, '1, wd);
        for (int c = 0; c < 300 && rq_id.size() < 1; c++) begin
            mem_ready = (c % 3 == 0);
            step();
        end
        mem_ready = 1'b1;
        check("bp_resp", rq_id.size(), 1);
        check("bp_beats", log_addr.size(), 8);
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 8; j++) e64[j*8 +: 8] = 8'(8 * k + j);
            check("bp_addr", log_addr[k], 64'h4000 + 64'(8 * k));
            check("bp_data", log_data[k], e64);
        end
        check("bp_stable", stall_bad, 0);
        check("bp_stalled", stall_seen > 0, 1);

        // Partial strobe: only beat 1 enabled
        clear_logs();
        issue(8'h22, 8'h00, 64'h5000, 64'h0000_0000_0000_FF00, wd);
        wait_resp(1);
        check("ps_beats", log_addr.size(), 8);
        for (int k = 0; k < 8; k++) check("ps_strb", log_strb[k], (k == 1) ? 8'hFF : 8'h00);

        // Back-to-back reads
        clear_logs();
        issue(8'h05, 8'h01, 64'h1000, '0, '0);
        for (int c = 0; c < 200 && s_resp == 8'h00; c++) step();
        check("b2b_first", s_resp, 8'h05);
        step();
        issue(8'h06, 8'h01, 64'h3000, '0, '0);
        wait_resp(2);
        check("b2b_id0", rq_id[0], 8'h05);
        check("b2b_id1", rq_id[1], 8'h06);
        check("b2b_ofst1", rq_ofst[1], 64'h3000);
        check("b2b_data1", rq_dat[1], exp_rd);
        check("b2b_beats", log_addr.size(), 16);
        check("b2b_last_a", log_addr[7], 64'h1038);
        check("b2b_first_b", log_addr[8], 64'h3000);

        // Stray return pulses while idle must not disturb the next read
        inj_rv = 1'b1;
        step();
        step();
        inj_rv = 1'b0;
        step();
        clear_logs();
        issue(8'h33, 8'h01, 64'h5040, '0, '0);
        wait_resp(1);
        check("stray_id", rq_id[0], 8'h33);
        check("stray_data", rq_dat[0], exp_rd);

        // Reset after 3 read beats
        clear_logs();
        issue(8'h09, 8'h01, 64'h6000, '0, '0);
        for (int c = 0; c < 50 && log_addr.size() < 3; c++) begin
            @(negedge clk);
            #1;
        end
        check("mr_beats_before", log_addr.size(), 3);
        rst = 1'b0;
        #1;
        check("mr_req", mem_req, 0);
        check("mr_resp", s_resp, 0);
        check("mr_we", mem_we, 0);
        step();
        rst = 1'b1;
        step();
        step();
        step();
        check("mr_no_resp", rq_id.size(), 0);
        check("mr_idle_req", mem_req, 0);
        clear_logs();
        issue(8'h07, 8'h01, 64'h7000, '0, '0);
        wait_resp(1);
        check("mr_next_id", rq_id[0], 8'h07);
        check("mr_next_ofst", rq_ofst[0], 64'h7000);
        check("mr_next_data", rq_dat[0], exp_rd);
        check("mr_next_beats", log_addr.size(), 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
